param_memory: RTL and testbench
===============================

# param_memory

Parametrised single-port word memory for the CPU data/instruction path, the next generation of the fixed 16K x 32 bank. It adds configurable width, depth and read latency, per-byte write enables, a valid/ready request handshake with a pipelined in-order response channel, out-of-range error reporting, and a multi-cycle background clear after reset. It sits between the CPU load/store unit and storage, one request per cycle, single clock domain.

## Interface
- DATA_W, 32, data word width in bits; multiple of 8
- ADDR_W, 32, request address width; word address, not byte address
- DEPTH, 16384, number of words; valid addresses 0..DEPTH-1
- RD_LATENCY, 1, cycles from request acceptance to response; legal range 1..4
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents untouched by reset

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_be  in  DATA_W/8  byte enables for writes; bit k covers data bits [8k+7:8k]; ignored for reads
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present for exactly one cycle; no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  request address >= DEPTH
- busy  out  1  clear in progress or rst asserted

## Operation
- States: RESET (rst high), CLEAR, RUN.
- While rst = 1: req_ready = 0, busy = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. The response pipeline is flushed and in-flight requests are dropped without response.
- First cycle after rst falls:
  - CLEAR_ON_RESET = 1: enter CLEAR. An internal index starts at 0 and writes 0 to one word per cycle up to DEPTH-1, then enters RUN.
  - CLEAR_ON_RESET = 0: enter RUN directly.
- CLEAR: req_ready = 0, busy = 1. If rst is reasserted, the clear restarts from index 0 after release.
- RUN: req_ready = 1, busy = 0. A request is accepted on a rising edge with req_valid & req_ready.
- Write accepted, address in range:
  - Each byte with req_be[k] = 1 is replaced from req_wdata at the accept edge.
  - Other bytes are unchanged. req_be = 0 is a legal no-op write.
- Read accepted, address in range: the word is sampled at the accept edge and returned after RD_LATENCY.
- Every accepted request produces exactly one response, in acceptance order.
  - Writes return rsp_rdata = 0, rsp_err = 0.
- Address >= DEPTH, compared at full ADDR_W with no truncation or wrap:
  - The array is not accessed.
  - The response has rsp_err = 1 and rsp_rdata = 0.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. The pipeline never returns stale data.

## Timing
- Request accepted at edge N: rsp_valid is high in the cycle after edge N+RD_LATENCY-1. RD_LATENCY = 1 gives the response in the cycle immediately after acceptance.
- Throughput is one request per cycle. Back-to-back requests give back-to-back responses.
- Clear duration is exactly DEPTH cycles. With rst falling before edge R, req_ready rises in the cycle after edge R+DEPTH-1.
- rsp_* are registered outputs. req_ready and busy are registered from state, with no combinational path from req_valid.
- rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.

## Test plan
- Reset clear, DEPTH=16, CLEAR_ON_RESET=1: pre-load garbage, pulse rst, count cycles -> busy high and req_ready low for 16 cycles after release; reads of 0..15 all return 0x00000000.
- Byte enables: write 0xAABBCCDD to addr 5 (be=4'hF), then write 0x11223344 with be=4'b0101 -> read of addr 5 returns 0xAA22CC44.
- Latency/pipelining, RD_LATENCY=3: four back-to-back reads of addrs 0..3 holding 10,20,30,40 -> rsp_valid high for 4 consecutive cycles starting 3 cycles after first accept, data 10,20,30,40 in order.
- Out of range, DEPTH=16384: read addr 16384 and write addr 0xFFFFFFFF -> both respond with rsp_err=1 and rdata=0; addr 0 is unmodified.
- RAW hazard: write 0x12345678 to addr 7, read addr 7 next cycle -> rsp_rdata=0x12345678.
- Reset mid-operation: 2 reads in flight with RD_LATENCY=4, assert rst one cycle -> no rsp_valid for the dropped requests; clear restarts from index 0.

Source files
------------

// File: rtl/param_memory_if.sv
// Request/response bus between the CPU load/store unit (master) and param_memory (slave).
// clk and rst are not carried here; they stay plain ports on each side.
interface param_memory_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DATA_W/8-1:0]   req_be;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic                  busy;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/param_memory.sv
// Parametrised single-port word memory with byte enables, in-order pipelined responses,
// out-of-range error reporting and a one-word-per-cycle background clear after reset.
module param_memory #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 16384,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic           clk,
  input logic           rst,
  param_memory_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] clr_idx;
  logic             clear_we;

  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_e;
  logic [DATA_W-1:0]     pipe_d [RD_LATENCY];

  // Ready/busy decode only the state register and rst, never req_valid.
  assign bus.req_ready = (state == ST_RUN) && !rst;
  assign bus.busy      = !bus.req_ready;

  assign accept   = bus.req_valid && bus.req_ready;
  assign in_range = {1'b0, bus.req_addr} < DEPTH_EXT;
  assign idx      = bus.req_addr[IDX_W-1:0];
  assign rd_word  = mem[idx];

  assign clear_we = !rst && (CLEAR_ON_RESET != 0) &&
                    (state == ST_RESET || state == ST_CLEAR);

  // NOTE: every clocked block uses non-blocking (<=) so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET;
      clr_idx <= '0;
    end else begin
      case (state)
        ST_RESET, ST_CLEAR: begin
          if (CLEAR_ON_RESET == 0 || clr_idx == LAST_IDX) begin
            state <= ST_RUN;
          end else begin
            state   <= ST_CLEAR;
            clr_idx <= clr_idx + 1'b1;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_RESET;
      endcase
    end
  end

  // NOTE: the array has no reset term; the clear sequence zeroes it so it still maps to RAM.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_idx] <= '0;
    end else if (accept && in_range && bus.req_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (bus.req_be[k]) begin
          mem[idx][8*k +: 8] <= bus.req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Stage 0 captures the response at the accept edge; the last stage drives rsp_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept && !in_range;
      pipe_d[0] <= (accept && in_range && !bus.req_we) ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign bus.rsp_valid = pipe_v[RD_LATENCY-1];
  assign bus.rsp_err   = pipe_e[RD_LATENCY-1];
  assign bus.rsp_rdata = pipe_d[RD_LATENCY-1];

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue/array reference model.
module tb_param_memory;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int LAT    = 3;
  localparam int CLR    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  param_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  param_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_LATENCY(LAT), .CLEAR_ON_RESET(CLR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_run      = 1'b0;
  int          clear_left = 0;
  int          cyc        = 0;
  int          checks     = 0;
  int          errors     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: updated at each rising edge from the pre-edge inputs, compared mid-cycle.
  initial begin : model
    rsp_t r;
    bit   exp_v;
    bit   exp_ready;
    forever begin
      @(posedge clk);
      cyc++;
      exp_ready = !rst && m_run;
      if (rst) begin
        q.delete();
        m_run      = 1'b0;
        clear_left = (CLR != 0) ? DEPTH : 0;
      end else if (!m_run) begin
        if (clear_left > 0) begin
          m_mem[DEPTH - clear_left] = '0;
          clear_left--;
        end
        if (clear_left == 0) m_run = 1'b1;
      end else if (bus.req_valid && exp_ready) begin
        r.due = cyc + LAT - 1;
        r.e   = bus.req_addr >= DEPTH;
        r.d   = '0;
        if (!r.e) begin
          if (bus.req_we) begin
            for (int k = 0; k < 4; k++)
              if (bus.req_be[k]) m_mem[bus.req_addr][8*k +: 8] = bus.req_wdata[8*k +: 8];
          end else begin
            r.d = m_mem[bus.req_addr];
          end
        end
        q.push_back(r);
      end

      @(negedge clk);
      exp_ready = !rst && m_run;
      exp_v     = (q.size() > 0) && (q[0].due == cyc);
      check("ready", 64'(bus.req_ready), 64'(exp_ready));
      check("busy", 64'(bus.busy), 64'(!exp_ready));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
      check("rsp_rdata", 64'(bus.rsp_rdata), exp_v ? 64'(q[0].d) : 64'd0);
      check("rsp_err", 64'(bus.rsp_err), exp_v ? 64'(q[0].e) : 64'd0);
      if (exp_v) void'(q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_be    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    drive(1'b1, be, addr, wdata);
    step();
    idle();
  endtask

  // Issue one request and check its response exactly LAT cycles later.
  task automatic req_expect(input string name, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_d, input logic exp_e);
    drive(we, be, addr, wdata);
    step();
    idle();
    repeat (LAT - 1) step();
    check({name, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({name, "_rdata"}, 64'(bus.rsp_rdata), 64'(exp_d));
    check({name, "_err"}, 64'(bus.rsp_err), 64'(exp_e));
  endtask

  // Pulse rst for one edge, then count busy cycles and any stray responses until ready.
  task automatic reset_and_count(output int n, output int seen);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n    = 0;
    seen = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.rsp_valid === 1'b1) seen++;
      n++;
      step();
    end
  endtask

  initial begin : main
    int n;
    int seen;
    bit exp_v;
    int sel;

    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("first_clear_cycles", 64'(n), 64'(DEPTH));

    // Garbage everywhere, then reset must clear it all in DEPTH cycles.
    for (int a = 0; a < DEPTH; a++) write(32'(a), 4'hF, $urandom() | 32'h1);
    repeat (LAT) step();
    reset_and_count(n, seen);
    check("clear_cycles", 64'(n), 64'(DEPTH));
    for (int a = 0; a < DEPTH; a++) req_expect("clear_rd", 1'b0, 4'h0, 32'(a), 32'h0, 32'h0, 1'b0);

    // Byte enables.
    write(32'd5, 4'hF, 32'hAABBCCDD);
    write(32'd5, 4'b0101, 32'h11223344);
    req_expect("be_rd", 1'b0, 4'h0, 32'd5, 32'h0, 32'hAA22CC44, 1'b0);

    // Four back-to-back reads: responses on consecutive cycles, in order.
    for (int a = 0; a < 4; a++) write(32'(a), 4'hF, 32'(10 * (a + 1)));
    repeat (LAT + 1) step();
    for (int t = 0; t < 8; t++) begin
      if (t < 4) drive(1'b0, 4'h0, 32'(t), 32'h0);
      else idle();
      step();
      exp_v = (t >= LAT - 1) && (t <= LAT + 2);
      check("lat_valid", 64'(bus.rsp_valid), 64'(exp_v));
      check("lat_rdata", 64'(bus.rsp_rdata), exp_v ? 64'(10 * (t - LAT + 2)) : 64'd0);
    end
    idle();

    // Out-of-range: full-width compare, no wrap onto address 0.
    write(32'd0, 4'hF, 32'hCAFEF00D);
    req_expect("oor_rd", 1'b0, 4'h0, 32'd16, 32'h0, 32'h0, 1'b1);
    req_expect("oor_wr_max", 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0, 1'b1);
    req_expect("oor_wr_alias", 1'b1, 4'hF, 32'h0001_0000, 32'h6666_6666, 32'h0, 1'b1);
    req_expect("oor_addr0", 1'b0, 4'h0, 32'd0, 32'h0, 32'hCAFEF00D, 1'b0);
    req_expect("wr_rsp", 1'b1, 4'hF, 32'd3, 32'h7777_7777, 32'h0, 1'b0);

    // Read-after-write on consecutive cycles.
    drive(1'b1, 4'hF, 32'd7, 32'h12345678);
    step();
    req_expect("raw_rd", 1'b0, 4'h0, 32'd7, 32'h0, 32'h12345678, 1'b0);

    // Reset with two reads in flight: both dropped, clear restarts from index 0.
    write(32'd9, 4'hF, 32'hDEADBEEF);
    repeat (LAT) step();
    drive(1'b0, 4'h0, 32'd1, 32'h0);
    step();
    drive(1'b0, 4'h0, 32'd2, 32'h0);
    step();
    reset_and_count(n, seen);
    check("midop_clear_cycles", 64'(n), 64'(DEPTH));
    check("midop_dropped_rsp", 64'(seen), 64'd0);
    req_expect("midop_rd9", 1'b0, 4'h0, 32'd9, 32'h0, 32'h0, 1'b0);

    // Randomized traffic, with one reset pulse partway through.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500 || c == 1501) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        sel = $urandom_range(0, 9);
        drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              (sel == 0) ? $urandom() : (sel == 1) ? 32'(DEPTH) : 32'($urandom_range(0, DEPTH - 1)),
              $urandom());
      end else begin
        idle();
      end
      step();
    end
    rst = 1'b0;
    idle();
    repeat (DEPTH + LAT + 4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
